// File: rtl/bldc_deadtime_gen.sv
// BLDC gate dead-time generator.
// Three independent per-phase FSMs turn the raw high/low gate requests into
// gate drives with a programmable dead window between high-side and
// low-side conduction. A shared sticky FAULT flags simultaneous requests.
module bldc_deadtime_gen #(
  parameter int DT = 8,
  parameter int CW = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       AA,
  input  logic       BB,
  input  logic       CC,
  input  logic       FLT_CLR,
  output logic       A_HS,
  output logic       B_HS,
  output logic       C_HS,
  output logic       A_LS,
  output logic       B_LS,
  output logic       C_LS,
  output logic       FAULT,
  output logic [2:0] DEAD
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  // Reload value: DT-1 so that a dead window spans exactly DT cycles.
  localparam logic [CW-1:0] CNT_LOAD = CW'(DT - 32'sd1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [2:0]    rh_s;
  logic [2:0]    rl_s;
  logic [2:0]    cf_s;

  state_t        state_q [3];
  state_t        state_d [3];
  logic [CW-1:0] cnt_q   [3];
  logic [CW-1:0] cnt_d   [3];
  logic [2:0]    hs_q, hs_d;
  logic [2:0]    ls_q, ls_d;
  logic [2:0]    dead_q, dead_d;
  logic          fault_q, fault_d;

  assign rh_s = {C, B, A};
  assign rl_s = {CC, BB, AA};
  assign cf_s = rh_s & rl_s;

  // Per-phase next-state, dead counter and registered-output decode.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      if (!EN) begin
        // Disabled: hold every gate off and keep the window reloaded.
        state_d[p] = ST_DEAD;
        cnt_d[p]   = CNT_LOAD;
      end else if (cf_s[p]) begin
        // Conflicting requests: park in DEAD and restart the window.
        state_d[p] = ST_DEAD;
        cnt_d[p]   = CNT_LOAD;
      end else begin
        case (state_q[p])
          ST_IDLE: begin
            if (rh_s[p]) begin
              state_d[p] = ST_HIGH;
            end else if (rl_s[p]) begin
              state_d[p] = ST_LOW;
            end else begin
              state_d[p] = ST_IDLE;
            end
          end
          ST_HIGH: begin
            if (rh_s[p]) begin
              state_d[p] = ST_HIGH;
            end else begin
              state_d[p] = ST_DEAD;
              cnt_d[p]   = CNT_LOAD;
            end
          end
          ST_LOW: begin
            if (rl_s[p]) begin
              state_d[p] = ST_LOW;
            end else begin
              state_d[p] = ST_DEAD;
              cnt_d[p]   = CNT_LOAD;
            end
          end
          ST_DEAD: begin
            if (cnt_q[p] != CNT_ZERO) begin
              cnt_d[p] = cnt_q[p] - CNT_ONE;
            end else if (rh_s[p]) begin
              state_d[p] = ST_HIGH;
            end else if (rl_s[p]) begin
              state_d[p] = ST_LOW;
            end else begin
              state_d[p] = ST_IDLE;
            end
          end
          default: begin
            state_d[p] = ST_DEAD;
            cnt_d[p]   = CNT_LOAD;
          end
        endcase
      end
      hs_d[p]   = (state_d[p] == ST_HIGH);
      ls_d[p]   = (state_d[p] == ST_LOW);
      dead_d[p] = (state_d[p] == ST_DEAD);
    end
  end

  // Sticky fault: a conflict sets it, and set wins over a coincident clear.
  always_comb begin
    if (EN && (|cf_s)) begin
      fault_d = 1'b1;
    end else if (FLT_CLR && !(|cf_s)) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int p = 0; p < 3; p++) begin
        state_q[p] <= ST_DEAD;
        cnt_q[p]   <= CNT_LOAD;
      end
      hs_q    <= 3'b000;
      ls_q    <= 3'b000;
      dead_q  <= 3'b111;
      fault_q <= 1'b0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
      hs_q    <= hs_d;
      ls_q    <= ls_d;
      dead_q  <= dead_d;
      fault_q <= fault_d;
    end
  end

  assign A_HS  = hs_q[0];
  assign B_HS  = hs_q[1];
  assign C_HS  = hs_q[2];
  assign A_LS  = ls_q[0];
  assign B_LS  = ls_q[1];
  assign C_LS  = ls_q[2];
  assign DEAD  = dead_q;
  assign FAULT = fault_q;

endmodule

// File: tb/tb_bldc_deadtime_gen.sv
// Directed testbench for bldc_deadtime_gen (DT=8 instance plus a DT=1 instance).
module tb_bldc_deadtime_gen;

  logic CLK, RST_N, EN, A, B, C, AA, BB, CC, FLT_CLR;
  logic A_HS, B_HS, C_HS, A_LS, B_LS, C_LS, FAULT;
  logic [2:0] DEAD;
  logic d1_a_hs, d1_b_hs, d1_c_hs, d1_a_ls, d1_b_ls, d1_c_ls, d1_fault;
  logic [2:0] d1_dead;

  int total = 0;
  int bad   = 0;

  bldc_deadtime_gen #(.DT(8), .CW(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .A(A), .B(B), .C(C),
    .AA(AA), .BB(BB), .CC(CC), .FLT_CLR(FLT_CLR),
    .A_HS(A_HS), .B_HS(B_HS), .C_HS(C_HS),
    .A_LS(A_LS), .B_LS(B_LS), .C_LS(C_LS),
    .FAULT(FAULT), .DEAD(DEAD)
  );

  bldc_deadtime_gen #(.DT(1), .CW(8)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .A(A), .B(B), .C(C),
    .AA(AA), .BB(BB), .CC(CC), .FLT_CLR(FLT_CLR),
    .A_HS(d1_a_hs), .B_HS(d1_b_hs), .C_HS(d1_c_hs),
    .A_LS(d1_a_ls), .B_LS(d1_b_ls), .C_LS(d1_c_ls),
    .FAULT(d1_fault), .DEAD(d1_dead)
  );

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Inputs set before calling step are sampled at its rising edge; outputs
  // are then observed on the following falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Six-step table: high-side phase and low-side phase per step.
  int hi_tab [6] = '{0, 0, 1, 1, 2, 2};
  int lo_tab [6] = '{1, 2, 2, 0, 0, 1};

  initial begin
    logic [2:0] hs_v, ls_v, prev_hs, prev_ls;
    int  off_cnt [3];
    bit  last_side [3];
    bit  last_valid [3];
    int  gaps;

    RST_N = 1'b0; EN = 1'b0; FLT_CLR = 1'b0;
    A = 1'b0; B = 1'b0; C = 1'b0; AA = 1'b0; BB = 1'b0; CC = 1'b0;
    step();
    step();
    chk("rst_gates", {C_LS, B_LS, A_LS, C_HS, B_HS, A_HS}, 32'd0);
    chk("rst_dead", DEAD, 32'd7);
    chk("rst_fault", FAULT, 32'd0);
    chk("rst_dead_dt1", d1_dead, 32'd7);

    // Reset release with A requested: A_HS held off for 8 cycles.
    RST_N = 1'b1; EN = 1'b1; A = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("startup_a_hs", A_HS, (i == 8) ? 32'd1 : 32'd0);
      chk("startup_dead_a", DEAD[0], (i < 8) ? 32'd1 : 32'd0);
      chk("startup_dt1_a_hs", d1_a_hs, 32'd1);
    end
    chk("startup_others", {C_LS, B_LS, A_LS, C_HS, B_HS}, 32'd0);
    chk("startup_dead_all", DEAD, 32'd0);
    chk("startup_fault", FAULT, 32'd0);

    // Phase B: IDLE -> LOW, then LOW -> HIGH handover.
    BB = 1'b1;
    step();
    chk("b_ls_on", B_LS, 32'd1);
    chk("b_ls_on_dt1", d1_b_ls, 32'd1);
    step();
    chk("b_ls_hold", B_LS, 32'd1);
    BB = 1'b0; B = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      step();
      chk("hand_b_ls", B_LS, 32'd0);
      chk("hand_b_hs", B_HS, (j == 9) ? 32'd1 : 32'd0);
      chk("hand_dead_b", DEAD[1], (j < 9) ? 32'd1 : 32'd0);
      chk("hand_dt1_b_hs", d1_b_hs, (j >= 2) ? 32'd1 : 32'd0);
      chk("hand_dt1_b_ls", d1_b_ls, 32'd0);
    end

    // Phase C conflict for 3 cycles; clear attempt mid-conflict must lose.
    C = 1'b1; CC = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      FLT_CLR = (k == 2) ? 1'b1 : 1'b0;
      step();
      chk("cf_c_gates", {C_LS, C_HS}, 32'd0);
      chk("cf_fault", FAULT, 32'd1);
      chk("cf_dead_c", DEAD[2], 32'd1);
    end
    FLT_CLR = 1'b0; CC = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("cf_c_hs", C_HS, (j == 8) ? 32'd1 : 32'd0);
      chk("cf_fault_sticky", FAULT, 32'd1);
    end
    FLT_CLR = 1'b1;
    step();
    chk("flt_clr", FAULT, 32'd0);
    FLT_CLR = 1'b0;
    step();
    chk("flt_stays_clr", FAULT, 32'd0);

    // EN dropped for one cycle while all high sides conduct.
    chk("pre_en_a_hs", A_HS, 32'd1);
    EN = 1'b0;
    step();
    chk("en_off_gates", {C_LS, B_LS, A_LS, C_HS, B_HS, A_HS}, 32'd0);
    chk("en_off_dead", DEAD, 32'd7);
    EN = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("en_back_a_hs", A_HS, (j == 8) ? 32'd1 : 32'd0);
      chk("en_back_b_hs", B_HS, (j == 8) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of a dead window (cnt=3): window restarts at 7.
    A = 1'b0;
    step();
    chk("a_off", A_HS, 32'd0);
    for (int j = 0; j < 4; j++) step();
    RST_N = 1'b0;
    step();
    chk("midrst_gates", {C_LS, B_LS, A_LS, C_HS, B_HS, A_HS}, 32'd0);
    chk("midrst_dead", DEAD, 32'd7);
    RST_N = 1'b1; A = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("midrst_a_hs", A_HS, (j == 8) ? 32'd1 : 32'd0);
      chk("midrst_c_hs", C_HS, (j == 8) ? 32'd1 : 32'd0);
    end

    // Six-step commutation for 3 electrical cycles, 25 clocks per step.
    prev_hs = {C_HS, B_HS, A_HS};
    prev_ls = {C_LS, B_LS, A_LS};
    for (int p = 0; p < 3; p++) begin
      off_cnt[p]    = 0;
      last_side[p]  = 1'b0;
      last_valid[p] = 1'b0;
    end
    gaps = 0;
    for (int s = 0; s < 18; s++) begin
      A  = (hi_tab[s % 6] == 0); B  = (hi_tab[s % 6] == 1); C  = (hi_tab[s % 6] == 2);
      AA = (lo_tab[s % 6] == 0); BB = (lo_tab[s % 6] == 1); CC = (lo_tab[s % 6] == 2);
      for (int t = 0; t < 25; t++) begin
        step();
        hs_v = {C_HS, B_HS, A_HS};
        ls_v = {C_LS, B_LS, A_LS};
        for (int p = 0; p < 3; p++) begin
          chk("six_overlap", {31'd0, hs_v[p] & ls_v[p]}, 32'd0);
          if (hs_v[p] && !prev_hs[p] && last_valid[p] && last_side[p]) begin
            chk("six_gap_to_hs", (off_cnt[p] >= 8) ? 32'd1 : 32'd0, 32'd1);
            gaps++;
          end
          if (ls_v[p] && !prev_ls[p] && last_valid[p] && !last_side[p]) begin
            chk("six_gap_to_ls", (off_cnt[p] >= 8) ? 32'd1 : 32'd0, 32'd1);
            gaps++;
          end
          if (hs_v[p]) begin
            last_side[p] = 1'b0; last_valid[p] = 1'b1; off_cnt[p] = 0;
          end else if (ls_v[p]) begin
            last_side[p] = 1'b1; last_valid[p] = 1'b1; off_cnt[p] = 0;
          end else begin
            off_cnt[p]++;
          end
        end
        prev_hs = hs_v;
        prev_ls = ls_v;
      end
    end
    chk("six_handovers_seen", (gaps >= 15) ? 32'd1 : 32'd0, 32'd1);
    chk("six_fault", FAULT, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bldc_deadtime_gen.md
Name: bldc_deadtime_gen

Overview:
Downstream stage of the BLDC commutation block. Consumes the six raw gate requests (A, B, C high-side; AA, BB, CC low-side) and drives the power-stage gate pins. Per phase, it inserts a programmable dead time between any high-side and low-side conduction, and blocks shoot-through. It also flags illegal simultaneous requests with a sticky fault bit.

Parameters:
DT, 8, dead-time length in CLK cycles (legal range 1..255; 320 ns at 25 MHz)
CW, 8, width of the per-phase dead-time counter; must satisfy DT <= 2^CW-1

Ports:
CLK  input  1  system clock; all logic on rising edge
RST_N  input  1  synchronous reset, active-low
EN  input  1  gate enable; 0 forces all gates off
A  input  1  phase A high-side request
B  input  1  phase B high-side request
C  input  1  phase C high-side request
AA  input  1  phase A low-side request
BB  input  1  phase B low-side request
CC  input  1  phase C low-side request
FLT_CLR  input  1  clears FAULT
A_HS  output  1  phase A high-side gate
B_HS  output  1  phase B high-side gate
C_HS  output  1  phase C high-side gate
A_LS  output  1  phase A low-side gate
B_LS  output  1  phase B low-side gate
C_LS  output  1  phase C low-side gate
FAULT  output  1  sticky: a phase saw both of its requests high
DEAD  output  3  per-phase dead-window status, bit0=A, bit1=B, bit2=C

Behaviour:
- Interface: one clock (CLK). Reset is synchronous and active-low (RST_N).
- Structure: three identical, independent per-phase FSMs plus one shared FAULT register. There is no cross-phase interaction.
- Per-phase request decode: rh = high-side request, rl = low-side request, cf = rh & rl.
- Per-phase states:
  - IDLE: both gates off, dead time already satisfied.
  - HIGH: HS=1.
  - LOW: LS=1.
  - DEAD: both gates off, counter running.
- All outputs are registered and decoded from state: HS=(state==HIGH), LS=(state==LOW), DEAD bit=(state==DEAD).
- Reset (RST_N=0 at an edge):
  - Every phase goes to DEAD with cnt=DT-1.
  - FAULT=0.
  - All gate outputs 0; DEAD=3'b111.
  - Reset takes effect mid-operation the same way, with no partial state kept.
- EN=0 at an edge: every phase is forced to DEAD and cnt reloads DT-1 on every such edge, so gates stay off. After EN returns to 1, no gate turns on for DT cycles.
- Transitions, evaluated only when RST_N=1 and EN=1:
  - IDLE:
    - rh&!rl -> HIGH.
    - rl&!rh -> LOW.
    - Otherwise stay IDLE.
  - HIGH: stay while rh&!rl. Otherwise -> DEAD, cnt<=DT-1.
  - LOW: stay while rl&!rh. Otherwise -> DEAD, cnt<=DT-1.
  - DEAD:
    - If cf, reload cnt<=DT-1.
    - Else if cnt!=0, decrement.
    - Else (cnt==0): rh -> HIGH, rl -> LOW, neither -> IDLE.
- Timing:
  - Turn-off is immediate: request drop at edge k gives a gate low after edge k (1-cycle latency).
  - Turn-on from IDLE also has 1-cycle latency.
  - A direct HS->LS handover keeps both gates off for exactly DT cycles.
- Conflict (cf=1 in any state, with EN=1):
  - That phase goes or stays in DEAD with cnt reloaded.
  - FAULT<=1 at the same edge.
  - The dead window restarts after the conflict clears.
- FAULT: sticky until FLT_CLR=1 at an edge with no cf on any phase. If set and clear coincide, set wins. FAULT does not gate outputs.
- Invariant at every cycle: never HS=1 and LS=1 on the same phase.
- Invariant at every cycle: any 1->0 on one side is followed by at least DT cycles of 0 on both sides before the other side rises.
- DT=1: one dead cycle.

Test Plan:
- Reset, then EN=1, A=1 held (DT=8) -> A_HS stays 0 for 8 cycles after reset release (DEAD[0]=1), then A_HS=1. All other gates 0; FAULT=0.
- Phase B steady LOW, then BB=0 and B=1 on the same edge -> B_LS=0 next cycle, B_HS=0 for exactly 8 cycles, then B_HS=1; DEAD[1]=1 throughout the gap.
- C=1 and CC=1 for 3 cycles from IDLE -> C_HS=C_LS=0 throughout, FAULT=1. Then CC=0: C_HS rises 8 cycles later. FAULT stays 1 until FLT_CLR pulse, then 0.
- EN dropped for 1 cycle while A_HS=1 -> A_HS=0 next cycle. With A still requested, A_HS returns 8 cycles after EN=1.
- Replay the commutation Hall sequence (six-step, 40 ns CLK, 1000 ns step) through the upstream block -> scoreboard confirms no HS/LS overlap and at least 8-cycle gaps on every phase for 3 electrical cycles.
- RST_N=0 mid-DEAD with cnt=3 -> next cycle all gates 0 and cnt=7. Rebuild with DT=1: handover gap is exactly 1 cycle.
